lsu_mem_port: RTL
=================

# lsu_mem_port

Load/store unit sitting between the EX stage and the data-memory bus. Consumes the decoded memory controls: store byte enables, load flag and func3. Drives a single-outstanding req/ack memory handshake and stalls the pipeline while the access is pending. Returns aligned, sign/zero-extended load data to writeback.

## Interface
Parameters:
- ADDR_W, 32, byte address width
- TMO_CYC, 64, cycles of BUSY without ack before abort (≥2)

Ports:
- clk  in  1  clock; all logic on rising edge
- rst_n  in  1  reset, synchronous, active-low
- ex_valid  in  1  EX stage holds a valid instruction
- ex_load  in  1  instruction is a load
- ex_dm_w_en  in  4  store byte enables, unshifted: 0001 SB, 0011 SH, 1111 SW, 0000 non-store
- ex_func3  in  3  memory width/sign field
- ex_addr  in  ADDR_W  effective byte address
- ex_wdata  in  32  rs2 store data
- lsu_stall  out  1  hold EX/IF; combinational
- wb_valid  out  1  one-cycle load result strobe
- wb_data  out  32  extended load result
- err  out  1  one-cycle pulse on timeout or trapped misalignment
- mem_req  out  1  request, held until ack
- mem_we  out  1  1 = write
- mem_addr  out  ADDR_W  word-aligned address ({addr[ADDR_W-1:2],2'b00})
- mem_be  out  4  lane enables
- mem_wdata  out  32  lane-placed store data
- mem_ack  in  1  completion; valid only while mem_req=1
- mem_rdata  in  32  read word, valid in the ack cycle

## Operation
- Memory op = ex_valid && (ex_load || ex_dm_w_en != 0). Anything else is ignored.
- FSM states:
  - IDLE: memory op → latch addr/func3/data/enables, go to BUSY.
  - BUSY: mem_req=1, outputs stable.
    - Ack with store → IDLE.
    - Ack with load → capture rdata, go to RESP.
    - Timeout → IDLE.
  - RESP: wb_valid=1 for exactly one cycle. Also accepts a new memory op exactly as IDLE does (→ BUSY), otherwise → IDLE.
- lsu_stall = (IDLE|RESP && memory op) || (BUSY && !mem_ack && !timeout_hit). It is low in the ack cycle so EX advances on that edge.
- Store lanes:
  - mem_be = ex_dm_w_en << addr[1:0], truncated to 4 bits.
  - mem_wdata: SB = byte replicated ×4, SH = halfword replicated ×2, SW = as is.
- Load extract: shift rdata right by addr[1:0]*8, then by func3:
  - 000 LB: sign-extend bit 7
  - 001 LH: sign-extend bit 15
  - 010 LW: full word
  - 100 LBU / 101 LHU: zero-extend
  - other: full shifted word
- mem_be for loads: 1111.
- Timeout:
  - Counter clears on BUSY entry and increments each BUSY cycle without ack.
  - timeout_hit = (count == TMO_CYC-1) && !mem_ack.
  - On timeout_hit: next cycle err=1, mem_req=0, state IDLE, no wb_valid.
- mem_ack while not BUSY is ignored.

## Timing
- Reset (rst_n=0 at an edge): state IDLE, counter 0. mem_req, mem_we, mem_be, mem_addr, mem_wdata, wb_valid, wb_data, err all 0. Reset mid-BUSY drops mem_req at that edge; a later ack is ignored.
- Accept at cycle T → mem_req=1 from T+1.
- Zero-wait memory (ack at T+1):
  - Store: mem_req=0 at T+2.
  - Load: wb_valid at T+2.
- Load latency = ack cycle + 1. Store completes at the ack edge.
- Back-to-back: a new op in RESP gives mem_req again in the next cycle; wb_valid and the new accept may coincide.
- err is never asserted together with mem_req.

## Configuration
- LSU_MISALIGN_TRAP_EN defined: misaligned accesses are checked at accept.
  - Misaligned = LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]≠0.
  - Such an access is not issued. lsu_stall is high only in the accept cycle. err=1 the next cycle, with no mem_req and no wb_valid.
- LSU_MISALIGN_TRAP_EN undefined: misaligned accesses are issued with the truncated lanes described above. err comes only from timeout.

## Test plan
- Reset: hold rst_n=0 two cycles with ex_valid=1 → all outputs 0, no mem_req.
- SB: addr 0x1003, wdata 0xA5, ack at T+3 → mem_addr 0x1000, be 1000, wdata 0xA5A5A5A5, stall T..T+2, mem_req T+1..T+3.
- LB: addr 0x2001, rdata 0x0000_8000, zero-wait → wb_valid at T+2, wb_data 0xFFFFFF80. Same with LBU → 0x00000080.
- Back-to-back: LW then SW, the second presented in the RESP cycle → mem_req high in two consecutive transactions, wb_valid coincident with the second accept.
- Timeout: TMO_CYC=4, never ack → mem_req for 4 cycles, then err pulse, stall low, state IDLE. A late ack is ignored.
- SH at addr 0x3001: with LSU_MISALIGN_TRAP_EN → err at T+1, no mem_req. Without it → be 0110, wdata halfword replicated.

Source files
------------

// File: rtl/lsu_mem_port.sv
// lsu_mem_port: single-outstanding load/store port between EX and the data-memory bus.
// Define LSU_MISALIGN_TRAP_EN to trap misaligned halfword/word accesses instead of issuing them.
module lsu_mem_port #(
    parameter int ADDR_W  = 32,
    parameter int TMO_CYC = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ex_valid,
    input  logic              ex_load,
    input  logic [3:0]        ex_dm_w_en,
    input  logic [2:0]        ex_func3,
    input  logic [ADDR_W-1:0] ex_addr,
    input  logic [31:0]       ex_wdata,
    output logic              lsu_stall,
    output logic              wb_valid,
    output logic [31:0]       wb_data,
    output logic              err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_be,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ack,
    input  logic [31:0]       mem_rdata
);
    localparam int CW = $clog2(TMO_CYC) + 1;
    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
    state_t            state_q;
    logic [ADDR_W-1:0] addr_q;
    logic [2:0]        func3_q;
    logic [3:0]        be_q;
    logic [31:0]       wdata_q;
    logic [31:0]       wb_data_q;
    logic              we_q;
    logic              err_q;
    logic [CW-1:0]     cnt_q;
    logic              busy;
    logic              mem_op;
    logic              misalign;
    logic              timeout_hit;
    logic [7:0]        be_wide;
    logic [31:0]       st_data;
    logic [31:0]       shifted;
    logic [31:0]       ld_data_d;
    assign busy        = state_q == BUSY;
    assign mem_op      = ex_valid && (ex_load || ex_dm_w_en != 4'b0000);
    assign timeout_hit = busy && cnt_q == CW'(TMO_CYC - 1) && !mem_ack;
    assign lsu_stall   = (!busy && mem_op) || (busy && !mem_ack && !timeout_hit);
`ifdef LSU_MISALIGN_TRAP_EN
    assign misalign = ex_load
        ? ((ex_func3[1:0] == 2'b01 && ex_addr[0]) || (ex_func3 == 3'b010 && ex_addr[1:0] != 2'b00))
        : ((ex_dm_w_en == 4'b0011 && ex_addr[0]) || (ex_dm_w_en == 4'b1111 && ex_addr[1:0] != 2'b00));
`else
    assign misalign = 1'b0;
`endif
    assign be_wide = {4'b0000, ex_dm_w_en} << ex_addr[1:0];
    assign st_data = ex_dm_w_en == 4'b0001 ? {4{ex_wdata[7:0]}}
                   : ex_dm_w_en == 4'b0011 ? {2{ex_wdata[15:0]}} : ex_wdata;
    assign shifted = mem_rdata >> {addr_q[1:0], 3'b000};
    always_comb begin
        ld_data_d = shifted;
        ld_data_d = func3_q == 3'b000 ? {{24{shifted[7]}}, shifted[7:0]}
                  : func3_q == 3'b001 ? {{16{shifted[15]}}, shifted[15:0]}
                  : func3_q == 3'b100 ? {24'b0, shifted[7:0]}
                  : func3_q == 3'b101 ? {16'b0, shifted[15:0]} : shifted;
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            func3_q   <= '0;
            be_q      <= '0;
            wdata_q   <= '0;
            wb_data_q <= '0;
            we_q      <= 1'b0;
            err_q     <= 1'b0;
            cnt_q     <= '0;
        end else begin
            err_q <= timeout_hit || (!busy && mem_op && misalign);
            case (state_q)
                BUSY: begin
                    if (mem_ack) begin
                        state_q <= we_q ? IDLE : RESP;
                        if (!we_q) wb_data_q <= ld_data_d;
                    end else if (timeout_hit) begin
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                default: begin
                    if (mem_op && !misalign) begin
                        state_q <= BUSY;
                        addr_q  <= ex_addr;
                        func3_q <= ex_func3;
                        we_q    <= !ex_load;
                        be_q    <= ex_load ? 4'b1111 : be_wide[3:0];
                        wdata_q <= st_data;
                        cnt_q   <= '0;
                    end else begin
                        state_q <= IDLE;
                    end
                end
            endcase
        end
    end
    assign mem_req   = busy;
    assign mem_we    = we_q;
    assign mem_addr  = {addr_q[ADDR_W-1:2], 2'b00};
    assign mem_be    = be_q;
    assign mem_wdata = wdata_q;
    assign wb_valid  = state_q == RESP;
    assign wb_data   = wb_data_q;
    assign err       = err_q;
endmodule
